// File: rtl/alu_arb_pkg.sv
// Shared widths, requester ids and counter width for the ALU issue arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 5;
    localparam int PERF_CNT_W = 32;

    typedef logic req_id_t;

    localparam req_id_t REQ_MAIN = 1'b0;
    localparam req_id_t REQ_AUX  = 1'b1;

endpackage

// File: rtl/alu_issue_arb_if.sv
// Request, ALU and response signal bundle; the arbiter takes the slave modport.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o/rsp_ready_i carry the valid/ready handshakes.
interface alu_issue_arb_if
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);

    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [DATA_W-1:0] req0_pc_i;
    logic [DATA_W-1:0] req0_instr_i;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [TAG_W-1:0]  req0_tag_i;
    logic [DATA_W-1:0] req1_pc_i;
    logic [DATA_W-1:0] req1_instr_i;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic [TAG_W-1:0]  req1_tag_i;

    logic [DATA_W-1:0] alu_pc_o;
    logic [DATA_W-1:0] alu_instr_o;
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [DATA_W-1:0] alu_result_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    req_id_t           rsp_id_o;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic [DATA_W-1:0] rsp_data_o;

    modport master (
        output req_valid_i, req0_pc_i, req0_instr_i, req0_a_i, req0_b_i, req0_tag_i,
               req1_pc_i, req1_instr_i, req1_a_i, req1_b_i, req1_tag_i,
               alu_result_i, rsp_ready_i,
        input  req_ready_o, alu_pc_o, alu_instr_o, alu_a_o, alu_b_o,
               rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req0_pc_i, req0_instr_i, req0_a_i, req0_b_i, req0_tag_i,
               req1_pc_i, req1_instr_i, req1_a_i, req1_b_i, req1_tag_i,
               alu_result_i, rsp_ready_i,
        output req_ready_o, alu_pc_o, alu_instr_o, alu_a_o, alu_b_o,
               rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin picker; the pointer flips to the other requester after each accept.
// Latency: grant is combinational from valid; pointer updates at the accepting edge.
// Backpressure: pointer holds whenever accept is low.
module alu_rr_arb2
    import alu_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rsn_i,
    input  logic [1:0] valid,
    input  logic       accept,
    output req_id_t    grant
);

    req_id_t rr_ptr;

    always_comb begin
        case (valid)
            2'b01:   grant = REQ_MAIN;
            2'b10:   grant = REQ_AUX;
            default: grant = rr_ptr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            rr_ptr <= REQ_MAIN;
        end else if (accept) begin
            rr_ptr <= ~grant;
        end
    end

endmodule

// File: rtl/alu_issue_arb.sv
// Round-robin issue arbiter feeding the shared ALU, with issue (A) and response (B) registers.
// Latency: accept at edge N gives rsp_valid_o after edge N+1; 1 op/cycle sustained.
// Backpressure: B stalls on !rsp_ready_i, A stalls behind B, req_ready_o drops; ALU_ARB_PERF_CNT_EN adds counters.
module alu_issue_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
)
(
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  flush_i,
    alu_issue_arb_if.slave        bus
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] grant0_cnt_o,
    output logic [PERF_CNT_W-1:0] grant1_cnt_o,
    output logic [PERF_CNT_W-1:0] conflict_cnt_o
`endif
);

    logic              a_valid;
    req_id_t           a_id;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_pc;
    logic [DATA_W-1:0] a_instr;
    logic [DATA_W-1:0] a_a;
    logic [DATA_W-1:0] a_b;

    logic              b_valid;
    req_id_t           b_id;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_data;

    logic              b_take;
    logic              a_adv;
    logic              a_take;
    logic              accept;
    req_id_t           grant;

    logic [DATA_W-1:0] sel_pc;
    logic [DATA_W-1:0] sel_instr;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [TAG_W-1:0]  sel_tag;

    assign b_take = !b_valid || bus.rsp_ready_i;
    assign a_adv  = a_valid && b_take;
    // Gating with rsn_i keeps req_ready_o low for the whole reset window.
    assign a_take = (!a_valid || a_adv) && !flush_i && rsn_i;
    assign accept = a_take && bus.req_valid_i[grant];

    alu_rr_arb2 u_rr_arb (
        .clk_i  (clk_i),
        .rsn_i  (rsn_i),
        .valid  (bus.req_valid_i),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.req_ready_o = !a_take            ? 2'b00 :
                             (grant == REQ_AUX) ? 2'b10 : 2'b01;

    always_comb begin
        sel_pc    = bus.req0_pc_i;
        sel_instr = bus.req0_instr_i;
        sel_a     = bus.req0_a_i;
        sel_b     = bus.req0_b_i;
        sel_tag   = bus.req0_tag_i;
        if (grant == REQ_AUX) begin
            sel_pc    = bus.req1_pc_i;
            sel_instr = bus.req1_instr_i;
            sel_a     = bus.req1_a_i;
            sel_b     = bus.req1_b_i;
            sel_tag   = bus.req1_tag_i;
        end
    end

    // Operand registers only load on accept so the ALU inputs hold while A is stalled.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            a_valid <= 1'b0;
            a_id    <= REQ_MAIN;
            a_tag   <= '0;
            a_pc    <= '0;
            a_instr <= '0;
            a_a     <= '0;
            a_b     <= '0;
        end else if (flush_i) begin
            a_valid <= 1'b0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_id    <= grant;
            a_tag   <= sel_tag;
            a_pc    <= sel_pc;
            a_instr <= sel_instr;
            a_a     <= sel_a;
            a_b     <= sel_b;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            b_valid <= 1'b0;
            b_id    <= REQ_MAIN;
            b_tag   <= '0;
            b_data  <= '0;
        end else if (flush_i) begin
            b_valid <= 1'b0;
        end else if (a_adv) begin
            b_valid <= 1'b1;
            b_id    <= a_id;
            b_tag   <= a_tag;
            b_data  <= bus.alu_result_i;
        end else if (bus.rsp_ready_i) begin
            b_valid <= 1'b0;
        end
    end

    assign bus.alu_pc_o    = a_pc;
    assign bus.alu_instr_o = a_instr;
    assign bus.alu_a_o     = a_a;
    assign bus.alu_b_o     = a_b;

    assign bus.rsp_valid_o = b_valid;
    assign bus.rsp_id_o    = b_id;
    assign bus.rsp_tag_o   = b_tag;
    assign bus.rsp_data_o  = b_data;

`ifdef ALU_ARB_PERF_CNT_EN
    // Counters ignore flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            grant0_cnt_o   <= '0;
            grant1_cnt_o   <= '0;
            conflict_cnt_o <= '0;
        end else begin
            if (accept && grant == REQ_MAIN) grant0_cnt_o <= grant0_cnt_o + 1'b1;
            if (accept && grant == REQ_AUX)  grant1_cnt_o <= grant1_cnt_o + 1'b1;
            if (&bus.req_valid_i && a_take) conflict_cnt_o <= conflict_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arb.sv
// Scoreboard bench for alu_issue_arb: accepted ops queue their expected result, responses pop it.
// The ALU is modelled as a + b; ALU_ARB_PERF_CNT_EN also exercises the performance counters.
module tb_alu_issue_arb;
    import alu_arb_pkg::*;

    typedef struct packed {
        logic        id;
        logic [4:0]  tag;
        logic [31:0] data;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rsn_i;
    logic flush_i;

    alu_issue_arb_if bus ();

`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    alu_issue_arb dut (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .flush_i (flush_i),
        .bus     (bus)
`ifdef ALU_ARB_PERF_CNT_EN
        ,
        .grant0_cnt_o   (grant0_cnt),
        .grant1_cnt_o   (grant1_cnt),
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    assign bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];
    int   k[2];

    function automatic logic [31:0] op_a(input int g, input int n);
        return 32'(g * 1000 + n * 7 + 1);
    endfunction

    function automatic logic [31:0] op_b(input int n);
        return 32'(n + 2);
    endfunction

    function automatic logic [4:0] op_tag(input int g, input int n);
        return 5'(g * 16 + n);
    endfunction

    task automatic present(input int g, input logic v);
        if (g == 0) begin
            bus.req0_pc_i    = 32'h1000 + 32'(k[0] * 4);
            bus.req0_instr_i = 32'h0020_81B3;
            bus.req0_a_i     = op_a(0, k[0]);
            bus.req0_b_i     = op_b(k[0]);
            bus.req0_tag_i   = op_tag(0, k[0]);
        end else begin
            bus.req1_pc_i    = 32'h2000 + 32'(k[1] * 4);
            bus.req1_instr_i = 32'h0040_0033;
            bus.req1_a_i     = op_a(1, k[1]);
            bus.req1_b_i     = op_b(k[1]);
            bus.req1_tag_i   = op_tag(1, k[1]);
        end
        bus.req_valid_i[g] = v;
    endtask

    // Samples both handshakes just before the next edge, updates the scoreboard, then steps one cycle.
    task automatic tick(output logic got, output rsp_t act, output rsp_t exp, output logic [1:0] acc);
        #1;
        acc = bus.req_valid_i & bus.req_ready_o;
        got = bus.rsp_valid_o && bus.rsp_ready_i;
        act = {bus.rsp_id_o, bus.rsp_tag_o, bus.rsp_data_o};
        exp = 'x;
        if (got && exp_q.size() > 0) exp = exp_q.pop_front();
        if (acc[0]) begin
            exp_q.push_back({1'b0, bus.req0_tag_i, bus.req0_a_i + bus.req0_b_i});
            k[0]++;
        end
        if (acc[1]) begin
            exp_q.push_back({1'b1, bus.req1_tag_i, bus.req1_a_i + bus.req1_b_i});
            k[1]++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rsn_i           = 1'b0;
        flush_i         = 1'b0;
        bus.req_valid_i = 2'b00;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        exp_q.delete();
        k[0] = 0;
        k[1] = 0;
    endtask

    task automatic test_reset();
        rsn_i           = 1'b0;
        flush_i         = 1'b0;
        bus.rsp_ready_i = 1'b1;
        k[0] = 0;
        k[1] = 0;
        present(0, 1'b1);
        present(1, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready_o); end
        total++; if (bus.alu_instr_o !== 32'h0) begin bad++; $display("FAIL reset_alu_instr: got %h want 0", bus.alu_instr_o); end
        total++; if (bus.alu_a_o !== 32'h0) begin bad++; $display("FAIL reset_alu_a: got %h want 0", bus.alu_a_o); end
        total++; if (bus.rsp_data_o !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data_o); end
        bus.req_valid_i = 2'b00;
        rsn_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single();
        logic got; rsp_t act, exp; logic [1:0] acc;
        bus.rsp_ready_i  = 1'b1;
        bus.req0_pc_i    = 32'h80;
        bus.req0_instr_i = 32'h0020_81B3;
        bus.req0_a_i     = 32'd5;
        bus.req0_b_i     = 32'd7;
        bus.req0_tag_i   = 5'd3;
        bus.req_valid_i  = 2'b01;
        #1;
        total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", bus.req_ready_o); end
        tick(got, act, exp, acc);
        bus.req_valid_i = 2'b00;
        total++; if (bus.alu_instr_o !== 32'h0020_81B3) begin bad++; $display("FAIL single_alu_instr: got %h want 002081b3", bus.alu_instr_o); end
        total++; if (bus.alu_a_o !== 32'd5 || bus.alu_b_o !== 32'd7) begin bad++; $display("FAIL single_alu_ops: got %0d,%0d want 5,7", bus.alu_a_o, bus.alu_b_o); end
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", bus.rsp_valid_o); end
        tick(got, act, exp, acc);
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL single_latency: rsp_valid got %b want 1", bus.rsp_valid_o); end
        total++; if ({bus.rsp_id_o, bus.rsp_tag_o, bus.rsp_data_o} !== {1'b0, 5'd3, 32'd12}) begin
            bad++; $display("FAIL single_rsp: got id=%0d tag=%0d data=%0d want id=0 tag=3 data=12", bus.rsp_id_o, bus.rsp_tag_o, bus.rsp_data_o);
        end
        tick(got, act, exp, acc);
        total++; if (!got || act !== exp) begin bad++; $display("FAIL single_sb: got %h want %h", act, exp); end
    endtask

    task automatic test_contention();
        logic got; rsp_t act, exp; logic [1:0] acc;
        logic [1:0] want_rdy;
        logic [6:0] got_pat = 7'b0111100;
        int nrsp = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            present(0, i < 4);
            present(1, i < 4);
            if (i < 4) begin
                #1;
                want_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
                total++; if (bus.req_ready_o !== want_rdy) begin bad++; $display("FAIL contention_grant%0d: got %b want %b", i, bus.req_ready_o, want_rdy); end
            end
            tick(got, act, exp, acc);
            total++; if (got !== got_pat[i]) begin bad++; $display("FAIL contention_rsp_slot%0d: got %b want %b", i, got, got_pat[i]); end
            if (got) begin
                total++; if (act !== exp || act.id !== 1'(nrsp % 2)) begin bad++; $display("FAIL contention_rsp%0d: got %h want %h", nrsp, act, exp); end
                nrsp++;
            end
        end
        total++; if (nrsp !== 4) begin bad++; $display("FAIL contention_count: got %0d want 4", nrsp); end
    endtask

    task automatic test_backpressure();
        logic got; rsp_t act, exp; logic [1:0] acc;
        int nrsp = 0;
        do_reset();
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            present(0, k[0] < 3);
            #1;
            total++; if (bus.req_ready_o !== ((i < 2) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL bp_ready%0d: got %b", i, bus.req_ready_o); end
            if (i >= 2) begin
                total++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== op_a(0, 0) + op_b(0) || bus.rsp_tag_o !== op_tag(0, 0)) begin
                    bad++; $display("FAIL bp_hold_b%0d: got v=%b d=%h t=%0d", i, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_tag_o);
                end
                total++; if (bus.alu_a_o !== op_a(0, 1) || bus.alu_b_o !== op_b(1)) begin
                    bad++; $display("FAIL bp_hold_a%0d: got %h,%h want %h,%h", i, bus.alu_a_o, bus.alu_b_o, op_a(0, 1), op_b(1));
                end
            end
            tick(got, act, exp, acc);
        end
        bus.rsp_ready_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            present(0, k[0] < 3);
            tick(got, act, exp, acc);
            if (got) begin
                total++; if (act !== exp) begin bad++; $display("FAIL bp_rsp%0d: got %h want %h", nrsp, act, exp); end
                nrsp++;
            end
        end
        total++; if (nrsp !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", nrsp); end
    endtask

    task automatic test_flush();
        logic got; rsp_t act, exp; logic [1:0] acc;
        int nrsp = 0;
        do_reset();
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            present(0, 1'b1);
            tick(got, act, exp, acc);
        end
        present(0, 1'b1);
        flush_i = 1'b1;
        #1;
        total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL flush_ready: got %b want 00", bus.req_ready_o); end
        tick(got, act, exp, acc);
        exp_q.delete();
        flush_i = 1'b0;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        bus.rsp_ready_i = 1'b1;
        present(0, 1'b1);
        present(1, 1'b1);
        #1;
        total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL flush_rr_kept: got %b want 10", bus.req_ready_o); end
        tick(got, act, exp, acc);
        bus.req_valid_i = 2'b00;
        for (int j = 0; j < 4; j++) begin
            tick(got, act, exp, acc);
            if (got) begin
                total++; if (act !== exp || act.id !== 1'b1) begin bad++; $display("FAIL flush_rsp: got %h want %h", act, exp); end
                nrsp++;
            end
        end
        total++; if (nrsp !== 1) begin bad++; $display("FAIL flush_count: got %0d want 1", nrsp); end
    endtask

    task automatic test_reset_mid();
        logic got; rsp_t act, exp; logic [1:0] acc;
        int nrsp = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            present(0, 1'b1);
            tick(got, act, exp, acc);
        end
        rsn_i = 1'b0;
        #1;
        total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL rstmid_ready: got %b want 00", bus.req_ready_o); end
        tick(got, act, exp, acc);
        if (got) begin
            total++; if (act !== exp) begin bad++; $display("FAIL rstmid_last_rsp: got %h want %h", act, exp); end
        end
        exp_q.delete();
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        total++; if (bus.alu_instr_o !== 32'h0) begin bad++; $display("FAIL rstmid_alu_instr: got %h want 0", bus.alu_instr_o); end
        rsn_i = 1'b1;
        bus.req_valid_i = 2'b00;
        present(1, 1'b1);
        #1;
        total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL rstmid_req1_grant: got %b want 10", bus.req_ready_o); end
        tick(got, act, exp, acc);
        bus.req_valid_i = 2'b00;
        for (int j = 0; j < 3; j++) begin
            tick(got, act, exp, acc);
            if (got) begin
                total++; if (act !== exp || act.id !== 1'b1) begin bad++; $display("FAIL rstmid_rsp: got %h want %h", act, exp); end
                nrsp++;
            end
        end
        total++; if (nrsp !== 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", nrsp); end
    endtask

    task automatic test_back_to_back();
        logic got; rsp_t act, exp; logic [1:0] acc;
        int nacc = 0;
        int nrsp = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            present(0, k[0] < 6);
            tick(got, act, exp, acc);
            if (i < 6 && acc == 2'b01) nacc++;
            if (i >= 2 && i < 8) begin
                total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b_bubble%0d: got %b want 1", i, got); end
            end
            if (got) begin
                total++; if (act !== exp) begin bad++; $display("FAIL b2b_rsp%0d: got %h want %h", nrsp, act, exp); end
                nrsp++;
            end
        end
        total++; if (nacc !== 6) begin bad++; $display("FAIL b2b_accepts: got %0d want 6", nacc); end
        total++; if (nrsp !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", nrsp); end
    endtask

`ifdef ALU_ARB_PERF_CNT_EN
    task automatic test_perf();
        logic got; rsp_t act, exp; logic [1:0] acc;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            present(0, i < 10);
            present(1, i < 10);
            tick(got, act, exp, acc);
            if (got) begin
                total++; if (act !== exp) begin bad++; $display("FAIL perf_rsp: got %h want %h", act, exp); end
            end
        end
        total++; if (grant0_cnt !== 32'd5) begin bad++; $display("FAIL perf_grant0: got %0d want 5", grant0_cnt); end
        total++; if (grant1_cnt !== 32'd5) begin bad++; $display("FAIL perf_grant1: got %0d want 5", grant1_cnt); end
        total++; if (conflict_cnt !== 32'd10) begin bad++; $display("FAIL perf_conflict: got %0d want 10", conflict_cnt); end
    endtask
`endif

    initial begin
        rsn_i            = 1'b0;
        flush_i          = 1'b0;
        bus.req_valid_i  = 2'b00;
        bus.rsp_ready_i  = 1'b1;
        bus.req0_pc_i    = '0; bus.req0_instr_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req0_tag_i = '0;
        bus.req1_pc_i    = '0; bus.req1_instr_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0; bus.req1_tag_i = '0;
        k[0] = 0;
        k[1] = 0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_ARB_PERF_CNT_EN
        test_perf();
`endif
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_arb.md
Name: alu_issue_arb

Overview:
- Two-requester issue arbiter and pipeline controller in front of the single shared integer ALU.
- Requester 0 is the main pipeline; requester 1 is the secondary issue source (replay / CSR path).
- Grants the ALU round-robin and registers the selected operands into an issue stage that drives the ALU.
- Captures the combinational ALU result into a response stage with valid/ready backpressure and a tag.

Parameters:
- DATA_W, 32, operand/result/pc/instr width
- TAG_W, 5, destination tag width (register index)

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all in-flight operations
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester accept
- req0_pc_i / req1_pc_i  in  DATA_W  pc
- req0_instr_i / req1_instr_i  in  DATA_W  instruction
- req0_a_i / req1_a_i  in  DATA_W  operand A
- req0_b_i / req1_b_i  in  DATA_W  operand B
- req0_tag_i / req1_tag_i  in  TAG_W  destination tag
- alu_pc_o, alu_instr_o, alu_a_o, alu_b_o  out  DATA_W  registered ALU inputs
- alu_result_i  in  DATA_W  combinational ALU output
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  1  requester that owns the response
- rsp_tag_o  out  TAG_W  tag
- rsp_data_o  out  DATA_W  result

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-low on rsn_i.
- Reset values: all valids 0, all data/tag/id registers 0, rr_ptr=0. Consequently rsp_valid_o=0, req_ready_o=2'b00 while rsn_i=0, and alu_*_o=0.
- Stage A (issue register): holds a_valid, a_id, a_tag, pc, instr, a, b. alu_*_o come straight from these registers and are held stable while A is stalled.
- Stage B (response register): holds b_valid, b_id, b_tag, b_data. b_data captures alu_result_i when A advances.
- Control equations:
  - b_take = !b_valid | rsp_ready_i
  - a_adv = a_valid & b_take
  - a_take = (!a_valid | a_adv) & !flush_i
- Arbitration:
  - Only one request valid: grant it.
  - Both valid: grant rr_ptr.
  - req_ready_o[g] = a_take & (grant==g); the other bit is 0.
  - Ready may depend combinationally on valid. Requesters must never make valid depend on ready.
- rr_ptr update: on any accepted request, rr_ptr <= ~granted id. No change otherwise.
- Latency and throughput:
  - Accepted at edge N, rsp_valid_o high after edge N+1 (2 cycles) when there is no backpressure.
  - Sustained throughput is 1 op/cycle.
- Backpressure: rsp_valid_o=1 with rsp_ready_i=0 holds B; A holds if full; req_ready_o=0 when A is full and not advancing. Response data, tag and id stay stable until accepted.
- Flush: flush_i=1 clears a_valid and b_valid at the edge, overrides any simultaneous accept or advance, forces req_ready_o=0, and leaves rr_ptr unchanged.
- Reset mid-operation: all in-flight ops are dropped with no response.
- Simultaneous response handshake and new accept in the same cycle is legal, with no bubble.

Optional Feature:
- Macro: ALU_ARB_PERF_CNT_EN
- Defined: adds outputs grant0_cnt_o, grant1_cnt_o, conflict_cnt_o (32 bits each).
  - grantN increments on each accept from requester N.
  - conflict increments each cycle both requests are valid and A can accept.
  - Counters wrap modulo 2^32, are cleared only by reset, and are unaffected by flush.
- Not defined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg: DATA_W/TAG_W defaults, requester-id type (1 bit), localparams REQ_MAIN=0 and REQ_AUX=1, counter width constant.
- Sub-module alu_rr_arb2: 2-way round-robin picker holding rr_ptr; inputs valid[1:0] and accept, output grant.

Test Plan:
- Single op: req0 add x3,x1,x2 (instr 0x002081B3), a=5, b=7, tag=3, rsp_ready=1. Expect rsp_valid 2 cycles later, data=12, tag=3, id=0.
- Contention: both valid for 4 cycles with rr_ptr=0 after reset. Expect grants 0,1,0,1 and responses in that id order, one per cycle.
- Backpressure: stream 3 ops, hold rsp_ready=0 for 5 cycles. Expect B holds op1 stable, A holds op2 with alu_* stable, req_ready=00; on release, ops 1,2,3 emerge in order with none lost or duplicated.
- Flush: A and B both full, assert flush_i with req0 valid. Expect req_ready=00 that cycle, rsp_valid=0 next cycle, and no response for the discarded ops.
- Reset: apply rsn_i=0 mid-stream. Expect the next cycle rsp_valid=0, alu_instr_o=0, and after release req1 alone granted immediately.
- Perf (ALU_ARB_PERF_CNT_EN): preload-free run of 10 contended cycles. Expect grant0=5, grant1=5, conflict=10.
